// File: rtl/pw_conv_scheduler.sv
// pw_conv_scheduler
// -----------------------------------------------------------------------------
// Frame-level sequencer for the pointwise-conv input path. Full-width pixels
// (OUT_CHANNEL channels) arrive on a valid/ready stream and are re-issued to
// the PW array as two IN_CHANNEL-wide half-beats, low half first. The block
// counts pixels against a frame length latched at start, flags the high half
// of the final pixel with m_last, and pulses done when the frame completes.
// Upstream bubbles and downstream stalls are both tolerated.
//
// OUT_CHANNEL must equal 2*IN_CHANNEL.
//
// Optional feature (macro PW_SCHED_PERF_EN): adds the stall_cnt output, a
// saturating 32-bit counter of cycles lost to downstream back-pressure or to
// missing input while waiting for a pixel. Without the macro the port and its
// logic are absent.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   start, cfg_pix_num   one-cycle frame start and frame length (pixels),
//                        sampled only while idle
//   abort                synchronous frame abort, highest priority
//   s_valid/s_ready/s_data   input pixel stream
//   m_valid/m_ready/m_data   output half-beat stream
//   m_half               0 = low half, 1 = high half
//   m_last               high half of the final pixel of the frame
//   busy                 high from accepted start until done
//   done                 one-cycle pulse at frame end
//   stall_cnt            (PW_SCHED_PERF_EN only) stall cycle counter
// -----------------------------------------------------------------------------
module pw_conv_scheduler #(
    parameter int DATA_WIDTH    = 8,
    parameter int IN_CHANNEL    = 9,
    parameter int OUT_CHANNEL   = 18,
    parameter int PIX_CNT_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              start,
    input  logic [PIX_CNT_WIDTH-1:0]          cfg_pix_num,
    input  logic                              abort,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [DATA_WIDTH*OUT_CHANNEL-1:0] s_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [DATA_WIDTH*IN_CHANNEL-1:0]  m_data,
    output logic                              m_half,
    output logic                              m_last,
    output logic                              busy,
    output logic                              done
`ifdef PW_SCHED_PERF_EN
    ,
    output logic [31:0]                       stall_cnt
`endif
);

    localparam int HALF_W = DATA_WIDTH * IN_CHANNEL;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e                   state_q, state_d;

    logic                     m_valid_q, m_valid_d;
    logic [HALF_W-1:0]        m_data_q,  m_data_d;
    logic                     m_half_q,  m_half_d;
    logic                     m_last_q,  m_last_d;
    logic [HALF_W-1:0]        hold_q,    hold_d;
    logic [PIX_CNT_WIDTH-1:0] cnt_q,     cnt_d;
    logic [PIX_CNT_WIDTH-1:0] cfg_q,     cfg_d;
    logic                     busy_q,    busy_d;
    logic                     done_q,    done_d;

    logic                     out_free;
    logic                     s_accept;
    logic                     last_pix;
    logic                     start_ok;

    // The output register may be reloaded when it is empty or its current
    // beat is being consumed this cycle.
    assign s_accept = s_valid && s_ready;
    assign last_pix = (cnt_q == (cfg_q - PIX_CNT_WIDTH'(1)));
    assign start_ok = start && (cfg_pix_num != '0);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. abort overrides every transition, including a start
    // arriving in the same cycle while idle.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start_ok) state_d = LO;
                LO:   if (s_accept) state_d = HI;
                HI:   if (out_free) state_d = last_pix ? DONE : LO;
                DONE: if (out_free) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic: input is only taken in LO, and only when the output
    // register can take the low half in the same cycle.
    always_comb begin
        out_free = !m_valid_q || m_ready;
        s_ready  = (state_q == LO) && out_free;
    end

    // Datapath next values. m_valid drops once its beat is consumed unless a
    // new beat is loaded in the same cycle; payload fields only change on a
    // load, so they hold stable while stalled.
    always_comb begin
        m_valid_d = m_valid_q && !m_ready;
        m_data_d  = m_data_q;
        m_half_d  = m_half_q;
        m_last_d  = m_last_q;
        hold_d    = hold_q;
        cnt_d     = cnt_q;
        cfg_d     = cfg_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (abort) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            busy_d    = 1'b0;
            cnt_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        cfg_d  = cfg_pix_num;
                        cnt_d  = '0;
                        busy_d = 1'b1;
                    end else if (start) begin
                        // Empty frame: report completion without going busy.
                        done_d = 1'b1;
                    end
                end
                LO: begin
                    if (s_accept) begin
                        m_data_d  = s_data[HALF_W-1:0];
                        m_half_d  = 1'b0;
                        m_last_d  = 1'b0;
                        m_valid_d = 1'b1;
                        hold_d    = s_data[2*HALF_W-1:HALF_W];
                    end
                end
                HI: begin
                    if (out_free) begin
                        m_data_d  = hold_q;
                        m_half_d  = 1'b1;
                        m_last_d  = last_pix;
                        m_valid_d = 1'b1;
                        cnt_d     = cnt_q + PIX_CNT_WIDTH'(1);
                    end
                end
                DONE: begin
                    if (out_free) begin
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_half_q  <= 1'b0;
            m_last_q  <= 1'b0;
            hold_q    <= '0;
            cnt_q     <= '0;
            cfg_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_half_q  <= m_half_d;
            m_last_q  <= m_last_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
            cfg_q     <= cfg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_half  = m_half_q;
    assign m_last  = m_last_q;
    assign busy    = busy_q;
    assign done    = done_q;

`ifdef PW_SCHED_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        stall_now;

    // A cycle counts once even if back-pressure and input starvation coincide.
    // An accepted start clears the count; it saturates rather than wrapping.
    always_comb begin
        stall_now   = (busy_q && m_valid_q && !m_ready) ||
                      ((state_q == LO) && !s_valid);
        stall_cnt_d = stall_cnt_q;
        if ((state_q == IDLE) && start_ok && !abort) begin
            stall_cnt_d = '0;
        end else if (stall_now && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pw_conv_scheduler.sv
// tb_pw_conv_scheduler
// -----------------------------------------------------------------------------
// Self-checking bench for pw_conv_scheduler. A table of frame descriptors is
// run with randomized upstream valid / downstream ready; a scoreboard built
// from the accepted pixels predicts every issued half-beat. Hand-written
// sequences cover empty frames, a downstream stall, abort, start while busy
// and reset mid-frame. Build with PW_SCHED_PERF_EN to also check stall_cnt.
// -----------------------------------------------------------------------------
module tb_pw_conv_scheduler;

    localparam int DW  = 8;
    localparam int IC  = 9;
    localparam int OC  = 18;
    localparam int PCW = 16;
    localparam int HW  = DW * IC;
    localparam int PW  = DW * OC;

    logic           clk = 1'b0;
    logic           rstn;
    logic           start;
    logic [PCW-1:0] cfg_pix_num;
    logic           abort;
    logic           s_valid;
    logic           s_ready;
    logic [PW-1:0]  s_data;
    logic           m_valid;
    logic           m_ready;
    logic [HW-1:0]  m_data;
    logic           m_half;
    logic           m_last;
    logic           busy;
    logic           done;
`ifdef PW_SCHED_PERF_EN
    logic [31:0]    stall_cnt;
`endif

    pw_conv_scheduler #(
        .DATA_WIDTH   (DW),
        .IN_CHANNEL   (IC),
        .OUT_CHANNEL  (OC),
        .PIX_CNT_WIDTH(PCW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .cfg_pix_num(cfg_pix_num),
        .abort      (abort),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_half     (m_half),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done)
`ifdef PW_SCHED_PERF_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [HW-1:0] data;
        logic          half;
        logic          last;
    } beat_t;

    typedef struct {
        int cfg;
        int vPct;
        int rPct;
        bit pattern;
        int expBeats;
        int expDone;
    } frameVec_t;

    int checks = 0;
    int fails  = 0;

    beat_t         expQ[$];
    logic [PW-1:0] srcQ[$];
    int            cfgCur    = 0;
    int            pixIdx    = 0;
    int            beatCnt   = 0;
    int            doneCnt   = 0;
    int            cycle     = 0;
    int            firstBeat = 0;
    int            lastBeat  = 0;
    bit            monEn     = 0;
    bit            srcEn     = 0;
    bit            sinkEn    = 0;
    bit            srcAccepted = 0;
    int            srcVPct   = 100;
    int            sinkRPct  = 100;

    bit            prevStall = 0;
    logic [HW-1:0] prevData;
    logic          prevHalf;
    logic          prevLast;
    beat_t         popped;

    task automatic checkOutput(input string name, input logic [127:0] act,
                               input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted pixel yields a low then a high half-beat;
    // the high half of pixel cfg-1 carries last. Stalled beats must hold.
    always @(negedge clk) begin
        if (monEn) begin
            cycle++;
            if (prevStall) begin
                checkOutput("hold m_valid", m_valid, 1'b1);
                checkOutput("hold m_data", m_data, prevData);
                checkOutput("hold m_half", m_half, prevHalf);
                checkOutput("hold m_last", m_last, prevLast);
            end
            if (m_valid && m_ready) begin
                checkOutput("beat expected", expQ.size() > 0, 1'b1);
                if (expQ.size() > 0) begin
                    popped = expQ.pop_front();
                    checkOutput("beat data", m_data, popped.data);
                    checkOutput("beat half", m_half, popped.half);
                    checkOutput("beat last", m_last, popped.last);
                end
                beatCnt++;
                if (beatCnt == 1) firstBeat = cycle;
                lastBeat = cycle;
            end
            if (s_valid && s_ready) begin
                checkOutput("accept with beats pending", expQ.size(), 0);
                checkOutput("accept within frame", pixIdx < cfgCur, 1'b1);
                expQ.push_back('{data: s_data[HW-1:0], half: 1'b0, last: 1'b0});
                expQ.push_back('{data: s_data[PW-1:HW], half: 1'b1,
                                 last: (pixIdx == cfgCur - 1)});
                pixIdx++;
                srcAccepted = 1;
            end
            if (done) doneCnt++;
            prevStall = m_valid && !m_ready;
            prevData  = m_data;
            prevHalf  = m_half;
            prevLast  = m_last;
        end
    end

    // Upstream source and downstream sink, driven just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (srcEn) begin
            if (srcAccepted) begin
                srcAccepted = 0;
                void'(srcQ.pop_front());
                s_valid = 1'b0;
            end
            if (!s_valid && srcQ.size() > 0 && $urandom_range(99) < srcVPct) begin
                s_valid = 1'b1;
                s_data  = srcQ[0];
            end
        end
        if (sinkEn) m_ready = ($urandom_range(99) < sinkRPct);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Loads nPix pixels, arms source/sink and issues a one-cycle start.
    // rPct < 0 leaves m_ready under manual control.
    task automatic applyStimulus(input int cfg, input int nPix, input int vPct,
                                 input int rPct, input bit pattern);
        logic [PW-1:0] pix;
        srcQ.delete();
        expQ.delete();
        for (int p = 0; p < nPix; p++) begin
            for (int k = 0; k < OC; k++) begin
                if (pattern) pix[k*DW +: DW] = (k < IC) ? 8'h01 : 8'h02;
                else         pix[k*DW +: DW] = 8'($urandom_range(255));
            end
            srcQ.push_back(pix);
        end
        cfgCur   = cfg;
        pixIdx   = 0;
        beatCnt  = 0;
        doneCnt  = 0;
        srcVPct  = vPct;
        srcAccepted = 0;
        s_valid  = 1'b0;
        srcEn    = 1;
        if (rPct >= 0) begin
            sinkRPct = rPct;
            sinkEn   = 1;
        end else begin
            sinkEn = 0;
        end
        start       = 1'b1;
        cfg_pix_num = PCW'(cfg);
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(input int maxCycles);
        bit seen;
        seen = 0;
        for (int i = 0; i < maxCycles && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        checkOutput("done within bound", seen, 1'b1);
        checkOutput("busy low at done", busy, 1'b0);
        checkOutput("m_valid low at done", m_valid, 1'b0);
    endtask

    frameVec_t vec[6];

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec[0] = '{cfg: 1, vPct: 100, rPct: 100, pattern: 1, expBeats: 2,  expDone: 1};
        vec[1] = '{cfg: 3, vPct: 100, rPct: 100, pattern: 0, expBeats: 6,  expDone: 1};
        vec[2] = '{cfg: 5, vPct: 60,  rPct: 70,  pattern: 0, expBeats: 10, expDone: 1};
        vec[3] = '{cfg: 8, vPct: 30,  rPct: 40,  pattern: 0, expBeats: 16, expDone: 1};
        vec[4] = '{cfg: 6, vPct: 90,  rPct: 20,  pattern: 0, expBeats: 12, expDone: 1};
        vec[5] = '{cfg: 2, vPct: 50,  rPct: 100, pattern: 0, expBeats: 4,  expDone: 1};

        rstn        = 1'b0;
        start       = 1'b0;
        cfg_pix_num = '0;
        abort       = 1'b0;
        s_valid     = 1'b0;
        s_data      = '0;
        m_ready     = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset s_ready", s_ready, 1'b0);
        checkOutput("reset m_valid", m_valid, 1'b0);
        checkOutput("reset m_half", m_half, 1'b0);
        checkOutput("reset m_last", m_last, 1'b0);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset done", done, 1'b0);
        checkOutput("reset m_data", m_data, '0);
`ifdef PW_SCHED_PERF_EN
        checkOutput("reset stall_cnt", stall_cnt, '0);
`endif
        rstn  = 1'b1;
        monEn = 1;
        tick();

        // Table-driven frames with randomized handshakes.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vec[i].cfg, vec[i].cfg, vec[i].vPct, vec[i].rPct,
                          vec[i].pattern);
            waitDone(3000);
            tick();
            tick();
            tick();
            checkOutput($sformatf("frame%0d beats", i), beatCnt, vec[i].expBeats);
            checkOutput($sformatf("frame%0d done pulses", i), doneCnt, vec[i].expDone);
            checkOutput($sformatf("frame%0d leftover beats", i), expQ.size(), 0);
            checkOutput($sformatf("frame%0d busy idle", i), busy, 1'b0);
            if (vec[i].vPct == 100 && vec[i].rPct == 100)
                checkOutput($sformatf("frame%0d beat span", i),
                            lastBeat - firstBeat, vec[i].expBeats - 1);
        end

        // Empty frame: done next cycle, never busy, no beats.
        srcEn   = 0;
        sinkEn  = 0;
        m_ready = 1'b1;
        doneCnt = 0;
        beatCnt = 0;
        start       = 1'b1;
        cfg_pix_num = '0;
        tick();
        start = 1'b0;
        @(negedge clk);
        checkOutput("empty done pulse", done, 1'b1);
        checkOutput("empty busy", busy, 1'b0);
        checkOutput("empty m_valid", m_valid, 1'b0);
        tick();
        @(negedge clk);
        checkOutput("empty done single", done, 1'b0);
        checkOutput("empty busy after", busy, 1'b0);
        tick();
        checkOutput("empty beats", beatCnt, 0);

        // Downstream stall of 4 cycles on the high half of pixel 0.
        m_ready = 1'b1;
        applyStimulus(2, 2, 100, -1, 0);
        begin
            bit seenLo;
            seenLo = 0;
            for (int i = 0; i < 20 && !seenLo; i++) begin
                @(negedge clk);
                if (m_valid && !m_half) seenLo = 1;
            end
            checkOutput("stall low half seen", seenLo, 1'b1);
        end
        tick();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("stall s_ready", s_ready, 1'b0);
            checkOutput("stall m_valid", m_valid, 1'b1);
            checkOutput("stall m_half", m_half, 1'b1);
            checkOutput("stall m_last", m_last, 1'b0);
            tick();
        end
        m_ready = 1'b1;
        waitDone(200);
        tick();
        checkOutput("stall beats", beatCnt, 4);
        checkOutput("stall done pulses", doneCnt, 1);
`ifdef PW_SCHED_PERF_EN
        checkOutput("stall_cnt", stall_cnt, 32'd4);
`endif

        // Abort after the low half of pixel 1, then a clean cfg=1 frame.
        applyStimulus(4, 4, 100, 100, 0);
        begin
            int loSeen;
            loSeen = 0;
            for (int i = 0; i < 40 && loSeen < 2; i++) begin
                @(negedge clk);
                if (m_valid && !m_half && m_ready) loSeen++;
            end
            checkOutput("abort low halves seen", loSeen, 2);
        end
        tick();
        abort   = 1'b1;
        srcEn   = 0;
        tick();
        abort   = 1'b0;
        s_valid = 1'b0;
        srcQ.delete();
        expQ.delete();
        srcAccepted = 0;
        doneCnt = 0;
        @(negedge clk);
        checkOutput("abort m_valid", m_valid, 1'b0);
        checkOutput("abort busy", busy, 1'b0);
        checkOutput("abort m_last", m_last, 1'b0);
        checkOutput("abort s_ready", s_ready, 1'b0);
        repeat (5) tick();
        checkOutput("abort no done", doneCnt, 0);
        applyStimulus(1, 1, 100, 100, 0);
        waitDone(100);
        tick();
        checkOutput("post-abort beats", beatCnt, 2);
        checkOutput("post-abort done pulses", doneCnt, 1);

        // Start while busy is ignored; frame completes with its own length.
        applyStimulus(3, 3, 100, 50, 0);
        tick();
        start       = 1'b1;
        cfg_pix_num = PCW'(7);
        tick();
        start = 1'b0;
        waitDone(500);
        repeat (3) tick();
        checkOutput("busy-start beats", beatCnt, 6);
        checkOutput("busy-start done pulses", doneCnt, 1);
        checkOutput("busy-start stays idle", busy, 1'b0);

        // Reset mid-frame returns outputs to reset values immediately.
        applyStimulus(5, 5, 100, 100, 0);
        repeat (3) tick();
        monEn = 0;
        srcEn = 0;
        sinkEn = 0;
        #1;
        rstn = 1'b0;
        #1;
        checkOutput("midreset m_valid", m_valid, 1'b0);
        checkOutput("midreset busy", busy, 1'b0);
        checkOutput("midreset s_ready", s_ready, 1'b0);
        checkOutput("midreset m_data", m_data, '0);
        checkOutput("midreset m_half", m_half, 1'b0);
        #10;
        rstn = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
